// File: rtl/prbs_cfg_sequencer.sv
// PRBS configuration sequencer: host-written shadow bank, active bank feeding
// the generator, and an FSM that applies commits either in place or through a
// stop / load / restart sequence when the pattern or bit rate changes.
module prbs_cfg_sequencer #(
   parameter int unsigned STOP_CYCLES = 16,
   parameter int unsigned PN_MAX      = 5
) (
   input  logic        dac_clk,
   input  logic        reset_n,
   input  logic        cfg_wr_en,
   input  logic [2:0]  cfg_addr,
   input  logic [31:0] cfg_wr_data,
   input  logic        cfg_commit,
   input  logic        prbs_valid,
   output logic        cfg_busy,
   output logic        cfg_err,
   output logic        prbs_mode_select,
   output logic [3:0]  prbs_pn_select_reg,
   output logic [31:0] prbs_bit_rate_config_reg,
   output logic [7:0]  prbs_edge_time_config_reg,
   output logic [15:0] prbs_amplitude_config_reg,
   output logic [15:0] prbs_dc_offset_config_reg
);

   // A zero hold time would skip the generator shutdown entirely; use one cycle.
   localparam int unsigned STOP_EFF = (STOP_CYCLES == 0) ? 1 : STOP_CYCLES;
   localparam int unsigned CNT_W    = (STOP_EFF < 2) ? 1 : $clog2(STOP_EFF);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STOP_EFF - 1);
   // The LOAD cycle is the last mode-off cycle, so STOP hands over one count early.
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'((STOP_EFF < 2) ? 0 : STOP_EFF - 2);
   localparam logic [9:0] TMO_LAST = 10'd1023;

   localparam logic [3:0]  RST_PN   = 4'd0;
   localparam logic [31:0] RST_RATE = 32'h1000_0000;
   localparam logic [7:0]  RST_EDGE = 8'd5;
   localparam logic [15:0] RST_AMP  = 16'h8000;
   localparam logic [15:0] RST_OFF  = 16'h0000;

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_STOP, S_LOAD, S_START} state_t;

   state_t            state_q, state_d;
   logic              mode_q, mode_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              reload_q, reload_d;
   logic [CNT_W-1:0]  stop_cnt_q, stop_cnt_d;
   logic [9:0]        tmo_q, tmo_d;

   logic [3:0]  sh_pn_q, sh_pn_d, act_pn_q, act_pn_d;
   logic [31:0] sh_rate_q, sh_rate_d, act_rate_q, act_rate_d;
   logic [7:0]  sh_edge_q, sh_edge_d, act_edge_q, act_edge_d;
   logic [15:0] sh_amp_q, sh_amp_d, act_amp_q, act_amp_d;
   logic [15:0] sh_off_q, sh_off_d, act_off_q, act_off_d;
   logic        sh_run_q, sh_run_d;

   logic wr_bad;
   logic commit_ok;
   logic disruptive;
   logic load_now;

   // Saturating stop-counter increment: the counter holds at its last value.
   function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
      return (c >= CNT_LAST) ? c : c + CNT_W'(1);
   endfunction

   // Host writes into the shadow bank; illegal pn codes and addresses are rejected.
   always_comb begin
      sh_pn_d   = sh_pn_q;
      sh_rate_d = sh_rate_q;
      sh_edge_d = sh_edge_q;
      sh_amp_d  = sh_amp_q;
      sh_off_d  = sh_off_q;
      sh_run_d  = sh_run_q;
      wr_bad    = 1'b0;
      if (cfg_wr_en) begin
         case (cfg_addr)
            3'd0: begin
               if ({28'd0, cfg_wr_data[3:0]} > PN_MAX) wr_bad = 1'b1;
               else                                    sh_pn_d = cfg_wr_data[3:0];
            end
            3'd1:    sh_rate_d = cfg_wr_data;
            3'd2:    sh_edge_d = cfg_wr_data[7:0];
            3'd3:    sh_amp_d  = cfg_wr_data[15:0];
            3'd4:    sh_off_d  = cfg_wr_data[15:0];
            3'd5:    sh_run_d  = cfg_wr_data[0];
            default: wr_bad    = 1'b1;
         endcase
      end
   end

   // Sequencer next-state logic; decisions use post-write shadow values.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      busy_d     = busy_q;
      reload_d   = reload_q;
      stop_cnt_d = stop_cnt_q;
      tmo_d      = tmo_q;
      load_now   = 1'b0;
      commit_ok  = cfg_commit && !busy_q;
      err_d      = wr_bad || (cfg_commit && busy_q);
      disruptive = (sh_pn_d != act_pn_q) || (sh_rate_d != act_rate_q);

      case (state_q)
         S_IDLE: begin
            mode_d = 1'b0;
            if (commit_ok) begin
               state_d  = S_LOAD;
               busy_d   = 1'b1;
               load_now = 1'b1;
            end else if (sh_run_d) begin
               state_d = S_START;
               mode_d  = 1'b1;
               tmo_d   = 10'd0;
            end
         end
         S_RUN: begin
            mode_d = 1'b1;
            busy_d = 1'b0;
            if (commit_ok && disruptive) begin
               busy_d     = 1'b1;
               reload_d   = 1'b1;
               mode_d     = 1'b0;
               stop_cnt_d = '0;
               if (STOP_EFF == 1) begin
                  state_d  = S_LOAD;
                  load_now = 1'b1;
               end else begin
                  state_d = S_STOP;
               end
            end else if (commit_ok) begin
               busy_d   = 1'b1;
               load_now = 1'b1;
            end else if (!sh_run_d) begin
               reload_d   = 1'b0;
               mode_d     = 1'b0;
               stop_cnt_d = '0;
               state_d    = S_STOP;
            end
         end
         S_STOP: begin
            mode_d = 1'b0;
            if (commit_ok) begin
               reload_d = 1'b1;
               busy_d   = 1'b1;
            end
            if (reload_d && (stop_cnt_q >= CNT_PRE)) begin
               state_d    = S_LOAD;
               stop_cnt_d = cnt_sat_inc(stop_cnt_q);
               load_now   = 1'b1;
            end else if (!reload_d && (stop_cnt_q >= CNT_LAST)) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               stop_cnt_d = cnt_sat_inc(stop_cnt_q);
            end
         end
         S_LOAD: begin
            reload_d = 1'b0;
            if (sh_run_d) begin
               state_d = S_START;
               mode_d  = 1'b1;
               tmo_d   = 10'd0;
            end else begin
               state_d = S_IDLE;
               mode_d  = 1'b0;
               busy_d  = 1'b0;
            end
         end
         S_START: begin
            mode_d = 1'b1;
            if (!sh_run_d) begin
               state_d = S_IDLE;
               mode_d  = 1'b0;
               busy_d  = 1'b0;
            end else if (commit_ok) begin
               state_d  = S_LOAD;
               mode_d   = 1'b0;
               busy_d   = 1'b1;
               load_now = 1'b1;
            end else if (prbs_valid) begin
               state_d = S_RUN;
               busy_d  = 1'b0;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_RUN;
               busy_d  = 1'b0;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 10'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            mode_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase

      act_pn_d   = act_pn_q;
      act_rate_d = act_rate_q;
      act_edge_d = act_edge_q;
      act_amp_d  = act_amp_q;
      act_off_d  = act_off_q;
      if (load_now) begin
         act_pn_d   = sh_pn_d;
         act_rate_d = sh_rate_d;
         act_edge_d = sh_edge_d;
         act_amp_d  = sh_amp_d;
         act_off_d  = sh_off_d;
      end
   end

   // State, banks and registered outputs; reset restores both banks identically.
   always_ff @(posedge dac_clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         mode_q     <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         reload_q   <= 1'b0;
         stop_cnt_q <= '0;
         tmo_q      <= 10'd0;
         sh_pn_q    <= RST_PN;
         sh_rate_q  <= RST_RATE;
         sh_edge_q  <= RST_EDGE;
         sh_amp_q   <= RST_AMP;
         sh_off_q   <= RST_OFF;
         sh_run_q   <= 1'b0;
         act_pn_q   <= RST_PN;
         act_rate_q <= RST_RATE;
         act_edge_q <= RST_EDGE;
         act_amp_q  <= RST_AMP;
         act_off_q  <= RST_OFF;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         reload_q   <= reload_d;
         stop_cnt_q <= stop_cnt_d;
         tmo_q      <= tmo_d;
         sh_pn_q    <= sh_pn_d;
         sh_rate_q  <= sh_rate_d;
         sh_edge_q  <= sh_edge_d;
         sh_amp_q   <= sh_amp_d;
         sh_off_q   <= sh_off_d;
         sh_run_q   <= sh_run_d;
         act_pn_q   <= act_pn_d;
         act_rate_q <= act_rate_d;
         act_edge_q <= act_edge_d;
         act_amp_q  <= act_amp_d;
         act_off_q  <= act_off_d;
      end
   end

   assign cfg_busy                  = busy_q;
   assign cfg_err                   = err_q;
   assign prbs_mode_select          = mode_q;
   assign prbs_pn_select_reg        = act_pn_q;
   assign prbs_bit_rate_config_reg  = act_rate_q;
   assign prbs_edge_time_config_reg = act_edge_q;
   assign prbs_amplitude_config_reg = act_amp_q;
   assign prbs_dc_offset_config_reg = act_off_q;

endmodule
